io_request_controller: RTL and testbench
========================================

Name: io_request_controller

Overview:
Sequences CPU input requests toward the two input sources: the switch bank qualified by the enter key, and the USART receiver.
- Holds the CPU in stall until the selected source delivers a word, then presents it for exactly one cycle.
- Debounces the enter key and handles the USART enable/ready handshake.
- Sits between the processor's IN/USART-read control lines and the input peripherals, on the divided clock.

Parameters:
DEBOUNCE_CYC, 16, cycles the key must stay stable before a press or release is accepted (min 1)
TIMEOUT_CYC, 4096, cycles allowed for dado_pronto after USART enable (IO_TIMEOUT_EN only)
CNT_W, 16, width of the shared debounce/timeout counter; must hold max(DEBOUNCE_CYC, TIMEOUT_CYC)

Ports:
clk  input  1  system clock (divided clock); all logic on rising edge
rst  input  1  synchronous, active-high reset
req_in  input  1  CPU requests switch input; level, held until ack
req_usart  input  1  CPU requests USART word; level, held until ack
chave  input  1  enter key, raw, active-high, asynchronous to clk
dados_sw  input  8  switch bank
dado_usart  input  32  USART received word
dado_pronto  input  1  USART word valid, level
habilitar_usart  output  1  USART receive enable
stall  output  1  CPU must freeze while high
dado_cpu  output  32  word returned to CPU
ack  output  1  one-cycle pulse; dado_cpu valid this cycle
timeout_err  output  1  sticky error flag (IO_TIMEOUT_EN only)

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE; counter 0.
- Key synchroniser flops 0.
- Reset mid-operation aborts the transfer with no ack.

Key path:
- chave passes through a 2-flop synchroniser, then the debouncer.
- Debouncer: the debounced level changes only after the synced level differs from it for DEBOUNCE_CYC consecutive cycles.
- Any bounce restarts the count.

FSM states: IDLE, KEY_PRESS, KEY_RELEASE, USART_WAIT, ACK.
- IDLE:
  - stall = req_in | req_usart, combinational, so the CPU stalls in the same cycle it raises a request.
  - req_in has priority over req_usart. req_in -> KEY_PRESS; else req_usart -> USART_WAIT.
- KEY_PRESS: wait for the debounced key to go 1, then latch {24'd0, dados_sw} into dado_cpu and go to KEY_RELEASE.
- KEY_RELEASE: wait for the debounced key to go 0 (one word per press), then go to ACK.
  - If the key is already held when the request arrives, the release must be seen first, so KEY_PRESS waits for a fresh press.
- USART_WAIT:
  - habilitar_usart = 1.
  - On the first cycle dado_pronto = 1, latch dado_usart, drop habilitar_usart next cycle, go to ACK.
- ACK:
  - ack = 1 and stall = 0 for exactly one cycle, then IDLE.
  - dado_cpu holds its value until the next latch.
- The CPU must deassert its request in the cycle after ack. A request still high in IDLE is treated as a new request.
- Request dropped while in KEY_PRESS, KEY_RELEASE or USART_WAIT: abort to IDLE, no ack, habilitar_usart = 0, dado_cpu unchanged.
- stall = 1 in KEY_PRESS, KEY_RELEASE and USART_WAIT.

Counter:
- Shared counter, cleared on every state entry.
- Saturates at 2^CNT_W-1; never wraps.

Optional Feature:
IO_TIMEOUT_EN
- Defined:
  - USART_WAIT counts cycles. Reaching TIMEOUT_CYC without dado_pronto forces dado_cpu = 32'hFFFF_FFFF, sets timeout_err, and goes to ACK.
  - timeout_err stays set until rst.
  - If dado_pronto and the timeout occur in the same cycle, the data wins and timeout_err is not set.
- Undefined: USART_WAIT waits indefinitely; timeout_err tied to 0; TIMEOUT_CYC unused.

Test Plan:
- Switch read with DEBOUNCE_CYC = 4:
  - Stimulus: dados_sw = 8'hA5; assert req_in; hold chave high 10 cycles, then low 10 cycles.
  - Response: stall high from the req_in cycle; exactly one ack with dado_cpu = 32'h0000_00A5, one cycle after the debounced release; no ack before release.
- Bounce rejection:
  - Stimulus: chave toggles 1/0 every 2 cycles for 20 cycles, then stays 0.
  - Response: no ack, stall stays 1.
- USART read:
  - Stimulus: assert req_usart; dado_pronto = 1 with dado_usart = 32'h1234_5678 on cycle 7.
  - Response: habilitar_usart = 1 from cycles 1 to 7; ack with 32'h1234_5678 in cycle 8.
- Simultaneous requests:
  - Stimulus: req_in and req_usart rise together.
  - Response: switch path served first (habilitar_usart stays 0); after its ack, USART_WAIT is entered while req_usart stays high.
- Reset / abort:
  - Stimulus: rst pulse during USART_WAIT, and separately req_usart dropped mid-wait.
  - Response: both cases leave habilitar_usart = 0 and stall = 0 next cycle with no ack.
- IO_TIMEOUT_EN with TIMEOUT_CYC = 8:
  - Stimulus: req_usart with no dado_pronto.
  - Response: ack with dado_cpu = 32'hFFFF_FFFF after 8 wait cycles; timeout_err = 1 and still 1 after a later good transfer.

Source files
------------

// File: rtl/io_request_controller.sv
// CPU input-request sequencer: switch bank qualified by a debounced enter key, or USART word.
// Optional USART receive timeout is compiled in with `define IO_TIMEOUT_EN.
module io_request_controller #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_in,
    input  logic        req_usart,
    input  logic        chave,
    input  logic [7:0]  dados_sw,
    input  logic [31:0] dado_usart,
    input  logic        dado_pronto,
    output logic        habilitar_usart,
    output logic        stall,
    output logic [31:0] dado_cpu,
    output logic        ack,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        KEY_PRESS,
        KEY_RELEASE,
        USART_WAIT,
        ACK
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             chave_p0, chave_p1;
    logic             key_db;
    logic             seen_low;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] cnt;
    logic             ld_sw, ld_usart, ld_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Stage p0/p1: two-flop synchroniser, then debounce on the synced level
    always_ff @(posedge clk) begin
        if (rst) begin
            chave_p0 <= 1'b0;
            chave_p1 <= 1'b0;
            key_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            chave_p0 <= chave;
            chave_p1 <= chave_p0;
            if (chave_p1 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                key_db <= chave_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= sat_inc(db_cnt);
            end
        end
    end

    // A press only counts once the key has been seen released inside KEY_PRESS
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seen_low <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state_nxt != state) ? '0 : sat_inc(cnt);
            seen_low <= (state == KEY_PRESS) && (seen_low || !key_db);
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

    always_comb begin
        state_nxt       = state;
        stall           = 1'b0;
        habilitar_usart = 1'b0;
        ack             = 1'b0;
        ld_sw           = 1'b0;
        ld_usart        = 1'b0;
        ld_to           = 1'b0;
        case (state)
            IDLE: begin
                stall = req_in | req_usart;
                if (req_in) begin
                    state_nxt = KEY_PRESS;
                end else if (req_usart) begin
                    state_nxt = USART_WAIT;
                end
            end
            KEY_PRESS: begin
                stall = 1'b1;
                if (!req_in) begin
                    state_nxt = IDLE;
                end else if (key_db && seen_low) begin
                    ld_sw     = 1'b1;
                    state_nxt = KEY_RELEASE;
                end
            end
            KEY_RELEASE: begin
                stall = 1'b1;
                if (!req_in) begin
                    state_nxt = IDLE;
                end else if (!key_db) begin
                    state_nxt = ACK;
                end
            end
            USART_WAIT: begin
                stall           = 1'b1;
                habilitar_usart = 1'b1;
                if (!req_usart) begin
                    state_nxt = IDLE;
                end else if (dado_pronto) begin
                    ld_usart  = 1'b1;
                    state_nxt = ACK;
                end
`ifdef IO_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    ld_to     = 1'b1;
                    state_nxt = ACK;
                end
`endif
            end
            ACK: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dado_cpu <= '0;
        end else if (ld_sw) begin
            dado_cpu <= {24'd0, dados_sw};
        end else if (ld_usart) begin
            dado_cpu <= dado_usart;
        end else if (ld_to) begin
            dado_cpu <= 32'hFFFF_FFFF;
        end
    end

`ifdef IO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (ld_to) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_request_controller.sv
// Directed bench for io_request_controller: switch read, bounce, USART read, priority, abort/reset, timeout.
module tb_io_request_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in, req_usart, chave, dado_pronto;
    logic [7:0]  dados_sw;
    logic [31:0] dado_usart;
    logic        habilitar_usart, stall, ack, timeout_err;
    logic [31:0] dado_cpu;

    int n_cmp = 0;
    int n_err = 0;

    io_request_controller #(
        .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC (8),
        .CNT_W       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in         (req_in),
        .req_usart      (req_usart),
        .chave          (chave),
        .dados_sw       (dados_sw),
        .dado_usart     (dado_usart),
        .dado_pronto    (dado_pronto),
        .habilitar_usart(habilitar_usart),
        .stall          (stall),
        .dado_cpu       (dado_cpu),
        .ack            (ack),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A cycle starts 1 time unit after a rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Key held high for cycles 0..9, low from cycle 10; the request drops in cycle 18.
    // Sync (2) + debounce (4) after the fall at cycle 10 -> debounced 0 in cycle 16, ack in cycle 17.
    task automatic switch_read(input logic [7:0] sw, input string tag);
        int acks;
        int ack_cyc;
        acks     = 0;
        ack_cyc  = -1;
        dados_sw = sw;
        req_in   = 1'b1;
        chave    = 1'b1;
        for (int c = 0; c < 19; c++) begin
            if (c == 10) chave = 1'b0;
            if (c == 18) req_in = 1'b0;
            @(negedge clk);
            if (c < 17) chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
            chk({tag, "_hab_off"}, {31'd0, habilitar_usart}, 32'd0);
            if (ack === 1'b1) begin
                acks++;
                ack_cyc = c;
                chk({tag, "_data"}, dado_cpu, {24'd0, sw});
            end
            next_cycle();
        end
        chk({tag, "_ack_count"}, 32'(acks), 32'd1);
        chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'd17);
    endtask

    initial begin
        rst         = 1'b1;
        req_in      = 1'b0;
        req_usart   = 1'b0;
        chave       = 1'b0;
        dado_pronto = 1'b0;
        dados_sw    = 8'h00;
        dado_usart  = 32'h0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hab", {31'd0, habilitar_usart}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data", dado_cpu, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Switch read of 8'hA5
        switch_read(8'hA5, "sw");

        // Bounce: toggling every 2 cycles never reaches 4 stable cycles
        req_in = 1'b1;
        for (int c = 0; c < 31; c++) begin
            chave = (c < 20) ? (((c / 2) % 2) == 0) : 1'b0;
            if (c == 30) req_in = 1'b0;
            @(negedge clk);
            chk("bounce_stall", {31'd0, stall}, 32'd1);
            chk("bounce_noack", {31'd0, ack}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("bounce_abort_stall", {31'd0, stall}, 32'd0);
        chk("bounce_data_kept", dado_cpu, 32'h0000_00A5);
        next_cycle();

        // USART read: request in cycle 0, word valid in cycle 7, ack in cycle 8
        req_usart = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 7) begin
                dado_pronto = 1'b1;
                dado_usart  = 32'h1234_5678;
            end
            if (c == 8) begin
                dado_pronto = 1'b0;
                dado_usart  = 32'h0;
            end
            if (c == 9) req_usart = 1'b0;
            @(negedge clk);
            chk("usart_hab", {31'd0, habilitar_usart}, {31'd0, (c >= 1 && c <= 7)});
            chk("usart_ack", {31'd0, ack}, {31'd0, (c == 8)});
            if (c <= 7) chk("usart_stall", {31'd0, stall}, 32'd1);
            if (c == 8) chk("usart_data", dado_cpu, 32'h1234_5678);
            chk("usart_terr", {31'd0, timeout_err}, 32'd0);
            next_cycle();
        end

        // Simultaneous requests: switch first, then USART while req_usart stays high
        req_usart = 1'b1;
        switch_read(8'h5A, "both");
        @(negedge clk);
        chk("both_usart_hab", {31'd0, habilitar_usart}, 32'd1);
        chk("both_usart_stall", {31'd0, stall}, 32'd1);
        next_cycle();

        // Abort by dropping req_usart mid-wait
        req_usart = 1'b0;
        @(negedge clk);
        chk("abort_noack0", {31'd0, ack}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("abort_hab", {31'd0, habilitar_usart}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_noack1", {31'd0, ack}, 32'd0);
        chk("abort_data_kept", dado_cpu, 32'h0000_005A);
        next_cycle();

        // Reset pulse during USART_WAIT
        req_usart = 1'b1;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("rstmid_hab_before", {31'd0, habilitar_usart}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        req_usart = 1'b0;
        @(negedge clk);
        chk("rstmid_hab", {31'd0, habilitar_usart}, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_noack", {31'd0, ack}, 32'd0);
        chk("rstmid_data", dado_cpu, 32'd0);
        next_cycle();

`ifdef IO_TIMEOUT_EN
        // Data arriving on the last wait cycle beats the timeout
        req_usart = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) begin
                dado_pronto = 1'b1;
                dado_usart  = 32'h0BAD_CAFE;
            end
            if (c == 9) dado_pronto = 1'b0;
            if (c == 10) req_usart = 1'b0;
            @(negedge clk);
            chk("race_ack", {31'd0, ack}, {31'd0, (c == 9)});
            if (c == 9) begin
                chk("race_data", dado_cpu, 32'h0BAD_CAFE);
                chk("race_terr", {31'd0, timeout_err}, 32'd0);
            end
            next_cycle();
        end

        // Timeout after 8 wait cycles (cycles 1..8), ack in cycle 9
        req_usart = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) req_usart = 1'b0;
            @(negedge clk);
            chk("to_hab", {31'd0, habilitar_usart}, {31'd0, (c >= 1 && c <= 8)});
            chk("to_ack", {31'd0, ack}, {31'd0, (c == 9)});
            if (c == 9) begin
                chk("to_data", dado_cpu, 32'hFFFF_FFFF);
                chk("to_terr", {31'd0, timeout_err}, 32'd1);
            end
            next_cycle();
        end

        // Good transfer afterwards leaves the error flag set
        req_usart   = 1'b1;
        dado_pronto = 1'b1;
        dado_usart  = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                req_usart   = 1'b0;
                dado_pronto = 1'b0;
            end
            @(negedge clk);
            chk("post_ack", {31'd0, ack}, {31'd0, (c == 2)});
            if (c == 2) chk("post_data", dado_cpu, 32'hCAFE_F00D);
            chk("post_terr", {31'd0, timeout_err}, 32'd1);
            next_cycle();
        end
`else
        // Without the timeout the wait is unbounded and the error flag stays 0
        req_usart = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("nto_noack", {31'd0, ack}, 32'd0);
            if (c >= 1) chk("nto_hab", {31'd0, habilitar_usart}, 32'd1);
            chk("nto_terr", {31'd0, timeout_err}, 32'd0);
            next_cycle();
        end
        req_usart = 1'b0;
        repeat (2) next_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
